// File: rtl/ram_bus_responder.sv
// rtl/ram_bus_responder.sv - RAM bus responder with a fixed-latency handshake and an internal 16-bit word array
// ramReady drops for ACCESS_LATENCY cycles per request; out-of-range accesses set a sticky addrError.
module ram_bus_responder #(
  parameter int DEPTH          = 128,
  parameter int ADDR_BITS      = 7,
  parameter int ACCESS_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:1] ramBusAddr,
  input  logic [15:0] ramBusDataIn,
  output logic [15:0] ramBusDataOut,
  input  logic        ramLatch,
  input  logic        ramInstruction,
  output logic        ramReady,
  output logic        addrError
);
  localparam int CNT_BITS = $clog2(ACCESS_LATENCY + 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY} state_t;

  state_t              state_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic [22:0]         addr_q;
  logic [15:0]         data_q;
  logic                wr_q;
  logic                ready_q;
  logic                err_q;
  logic [15:0]         dout_q;
  logic [15:0]         mem [DEPTH];

  logic in_range;
  logic done;

  // Full-width compare so high address bits never alias into the array.
  assign in_range = ({9'd0, addr_q} < DEPTH);
  assign done     = (state_q == S_BUSY) && (cnt_q == CNT_BITS'(ACCESS_LATENCY));

  // Storage is deliberately not reset; a reset mid-access leaves state_q in INIT so nothing commits.
  always_ff @(posedge clk) begin
    if (done && wr_q && in_range) begin
      mem[addr_q[ADDR_BITS-1:0]] <= data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
      ready_q <= 1'b0;
      dout_q  <= 16'h0000;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        S_IDLE: begin
          if (ramLatch == 1'b1) begin
            addr_q  <= ramBusAddr;
            data_q  <= ramBusDataIn;
            wr_q    <= ramInstruction;
            ready_q <= 1'b0;
            cnt_q   <= CNT_BITS'(1);
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (done) begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
            if (!wr_q) begin
              dout_q <= in_range ? mem[addr_q[ADDR_BITS-1:0]] : 16'h0000;
            end
            if (!in_range) begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_BITS'(1);
          end
        end
        default: begin
          state_q <= S_INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ramReady      = ready_q;
  assign ramBusDataOut = dout_q;
  assign addrError     = err_q;
endmodule
